inst_fifo_dual: RTL and testbench
=================================

// Module: inst_fifo_dual
// PURPOSE
//  Dual-issue instruction FIFO between fetch (I-cache, 2 words/cycle) and decode.
//  Read port 1 feeds the master pipeline; read port 2 feeds the slave pipeline
//    (instruction, pc_address, is_real_instruction).
//  Decouples fetch bandwidth from issue rate and discards all entries on flush.
// PARAMETERS
//  DEPTH      16   entry count; power of 2, >= 4
//  PTR_W      $clog2(DEPTH)   pointer width (derived, not overridden)
// PORTS
//  clk            in   1   clock, all state on posedge
//  rst            in   1   synchronous reset, active-low (rst==0 resets)
//  flush          in   1   discard all entries (exception/branch redirect)
//  write_en1      in   1   push entry 1
//  write_en2      in   1   push entry 2 (legal only with write_en1)
//  write_inst1    in   32  instruction 1
//  write_inst2    in   32  instruction 2
//  write_addr1    in   32  PC of instruction 1
//  write_addr2    in   32  PC of instruction 2
//  read_en1       in   1   master consumes head entry
//  read_en2       in   1   slave consumes head+1 (legal only with read_en1)
//  read_inst1     out  32  head instruction
//  read_inst2     out  32  head+1 instruction
//  read_addr1     out  32  head PC
//  read_addr2     out  32  head+1 PC
//  read_valid1    out  1   head entry is real (count>=1)
//  read_valid2    out  1   head+1 entry is real (count>=2)
//  full           out  1   count >= DEPTH-1; fetch must not push
//  empty          out  1   count == 0
// BEHAVIOUR
//  - Circular buffer, head/tail pointers PTR_W bits, wrap modulo DEPTH; count PTR_W+1 bits.
//  - Reset (rst==0) or flush: head=tail=count=0 next cycle; same-cycle pushes/pops ignored.
//    Reset has priority over flush.
//  - Push: entry1 -> tail, entry2 -> tail+1; tail += write_en1+write_en2.
//    Pushes while full are dropped; full is registered-count based, so !full guarantees 2 free slots.
//  - write_en2 without write_en1 is ignored entirely (no push, no tail move).
//  - Pop: n = read_en1 + (read_en2 & read_en1).
//    n is clipped to count: pop 2 with count==1 pops 1; pops when empty ignored.
//    Head += n.
//  - Simultaneous push/pop: count_next = count + pushes - pops, in the same cycle.
//  - Reads are first-word-fall-through, combinational from the head/head+1 registers.
//  - read_* = 0 and read_valid* = 0 when the entry is absent (empty, or count==1 for port 2).
//  - Outputs after reset: read_inst/addr 0, read_valid 0, full 0, empty 1.
//  - Pointer wrap: tail+1 and head+1 computed modulo DEPTH (DEPTH-1 -> 0).
// CONFIGURATION
//  INST_FIFO_BYPASS_EN defined:
//    - When empty and write_en1, the write data drives read port 1 in the same cycle,
//      with read_valid1=1; likewise write 2 -> port 2.
//    - Bypassed entries consumed the same cycle are not stored; tail and head both advance.
//    - Partial consumption stores only the unconsumed entries.
//    - During flush or reset, bypass is suppressed.
//  INST_FIFO_BYPASS_EN undefined: minimum latency push -> read_valid is 1 cycle.
// STRUCTURE
//  - Shared package sirius_pkg: typedef fifo_entry_t {logic [31:0] pc; logic [31:0] inst;}
//    and localparam INST_FIFO_DEPTH=16.
//  - Sub-module inst_fifo_ram: DEPTH x fifo_entry_t register file.
//    2 write ports (tail, tail+1), 2 async read ports (head, head+1), no reset on storage.
//  - Top holds pointers, count, flags, clip and bypass logic.
// TESTING
//  1. Reset with rst=0 for 2 cycles -> empty=1, full=0, read_valid1/2=0, read_* = 0.
//  2. Push pair (0x24020001 @0xBFC00000, 0x24030002 @0xBFC00004), no pops
//     -> next cycle read_valid1/2=1, read_addr1=0xBFC00000, read_addr2=0xBFC00004.
//  3. Fill with 8 pair-pushes, DEPTH=16
//     -> full=1 at count=15/16; a further push is dropped, count unchanged, no overwrite.
//  4. count=1, read_en1=read_en2=1 -> one pop only, empty=1 next cycle.
//     Then push 2 + pop 2 each cycle for 20 cycles -> count stable, head/tail wrap, order preserved.
//  5. count=6, flush=1 together with write_en1/2 -> next cycle empty=1, count=0,
//     and the pushed entries are absent.
//  6. INST_FIFO_BYPASS_EN, empty, push pair + read_en1 only
//     -> same cycle read_valid1=1 with pushed inst1; next cycle count=1, head=inst2.

Source files
------------

// File: rtl/sirius_pkg.sv
// Shared types for the sirius front end: the FIFO entry layout and default FIFO depth.
package sirius_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

    localparam int INST_FIFO_DEPTH = 16;

endpackage

// File: rtl/inst_fifo_ram.sv
// DEPTH x fifo_entry_t register file: two write ports, two asynchronous read ports.
// Storage is not reset; validity is tracked entirely by the pointer logic in the top.
import sirius_pkg::*;

module inst_fifo_ram #(
    parameter int DEPTH = INST_FIFO_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we1_i,
    input  logic              we2_i,
    input  logic [PTR_W-1:0]  waddr1_i,
    input  logic [PTR_W-1:0]  waddr2_i,
    input  fifo_entry_t       wdata1_i,
    input  fifo_entry_t       wdata2_i,
    input  logic [PTR_W-1:0]  raddr1_i,
    input  logic [PTR_W-1:0]  raddr2_i,
    output fifo_entry_t       rdata1_o,
    output fifo_entry_t       rdata2_o
);

    fifo_entry_t mem_q [DEPTH];

    // The two write addresses are always tail and tail+1, so they never collide.
    always_ff @(posedge clk) begin
        if (we1_i) mem_q[waddr1_i] <= wdata1_i;
        if (we2_i) mem_q[waddr2_i] <= wdata2_i;
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/inst_fifo_dual.sv
// Dual-issue instruction FIFO between fetch and decode, first-word-fall-through.
// Optional same-cycle bypass of an empty FIFO is enabled by defining INST_FIFO_BYPASS_EN.
import sirius_pkg::*;

module inst_fifo_dual #(
    parameter int DEPTH = INST_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        write_en1,
    input  logic        write_en2,
    input  logic [31:0] write_inst1,
    input  logic [31:0] write_inst2,
    input  logic [31:0] write_addr1,
    input  logic [31:0] write_addr2,
    input  logic        read_en1,
    input  logic        read_en2,
    output logic [31:0] read_inst1,
    output logic [31:0] read_inst2,
    output logic [31:0] read_addr1,
    output logic [31:0] read_addr2,
    output logic        read_valid1,
    output logic        read_valid2,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W:0]   n_push, n_req, n_pop, avail;
    logic             push_ok, wr_live, bypass_w;
    fifo_entry_t      wdata1, wdata2, rdata1, rdata2;

    assign full    = count_q >= (PTR_W+1)'(DEPTH - 1);
    assign empty   = count_q == '0;
    assign wr_live = rst & ~flush;

    // write_en2 alone is meaningless and is dropped along with pushes while full.
    assign push_ok = write_en1 & ~full;
    assign n_push  = push_ok ? (write_en2 ? (PTR_W+1)'(2) : (PTR_W+1)'(1)) : '0;

`ifdef INST_FIFO_BYPASS_EN
    assign bypass_w = empty & push_ok & wr_live;
`else
    assign bypass_w = 1'b0;
`endif

    // Bypassed entries are written to storage anyway; advancing head past them discards them.
    assign avail = bypass_w ? n_push : count_q;
    assign n_req = (PTR_W+1)'(read_en1) + (PTR_W+1)'(read_en1 & read_en2);
    assign n_pop = (n_req > avail) ? avail : n_req;

    always_comb begin
        head_d  = head_q + n_pop[PTR_W-1:0];
        tail_d  = tail_q + n_push[PTR_W-1:0];
        count_d = count_q + n_push - n_pop;
        if (!rst || flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    assign wdata1 = '{pc: write_addr1, inst: write_inst1};
    assign wdata2 = '{pc: write_addr2, inst: write_inst2};

    inst_fifo_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk      (clk),
        .we1_i    (push_ok & wr_live),
        .we2_i    (push_ok & write_en2 & wr_live),
        .waddr1_i (tail_q),
        .waddr2_i (tail_q + PTR_W'(1)),
        .wdata1_i (wdata1),
        .wdata2_i (wdata2),
        .raddr1_i (head_q),
        .raddr2_i (head_q + PTR_W'(1)),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    always_comb begin
        read_valid1 = 1'b0;
        read_valid2 = 1'b0;
        read_inst1  = '0;
        read_addr1  = '0;
        read_inst2  = '0;
        read_addr2  = '0;
        if (bypass_w) begin
            read_valid1 = 1'b1;
            read_inst1  = write_inst1;
            read_addr1  = write_addr1;
            if (write_en2) begin
                read_valid2 = 1'b1;
                read_inst2  = write_inst2;
                read_addr2  = write_addr2;
            end
        end else begin
            if (count_q >= (PTR_W+1)'(1)) begin
                read_valid1 = 1'b1;
                read_inst1  = rdata1.inst;
                read_addr1  = rdata1.pc;
            end
            if (count_q >= (PTR_W+1)'(2)) begin
                read_valid2 = 1'b1;
                read_inst2  = rdata2.inst;
                read_addr2  = rdata2.pc;
            end
        end
    end

endmodule

// File: tb/tb_inst_fifo_dual.sv
// Directed, table-driven bench for inst_fifo_dual (DEPTH=16); bypass checks need INST_FIFO_BYPASS_EN.
module tb_inst_fifo_dual;

    logic        clk = 1'b0;
    logic        rst, flush, write_en1, write_en2, read_en1, read_en2;
    logic [31:0] write_inst1, write_inst2, write_addr1, write_addr2;
    logic [31:0] read_inst1, read_inst2, read_addr1, read_addr2;
    logic        read_valid1, read_valid2, full, empty;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inst_fifo_dual dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .write_en1   (write_en1),
        .write_en2   (write_en2),
        .write_inst1 (write_inst1),
        .write_inst2 (write_inst2),
        .write_addr1 (write_addr1),
        .write_addr2 (write_addr2),
        .read_en1    (read_en1),
        .read_en2    (read_en2),
        .read_inst1  (read_inst1),
        .read_inst2  (read_inst2),
        .read_addr1  (read_addr1),
        .read_addr2  (read_addr2),
        .read_valid1 (read_valid1),
        .read_valid2 (read_valid2),
        .full        (full),
        .empty       (empty)
    );

    typedef struct {
        logic        fl, w1, w2, r1, r2;
        logic [31:0] i1, a1, i2, a2;
        logic        ev1, ev2, efull, eempty;
        logic [31:0] ei1, ea1, ei2, ea2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, w1, w2, r1, r2,
                                input logic [31:0] i1, a1, i2, a2,
                                input logic ev1, ev2, efull, eempty,
                                input logic [31:0] ei1, ea1, ei2, ea2);
        vec_t v;
        v.fl = fl; v.w1 = w1; v.w2 = w2; v.r1 = r1; v.r2 = r2;
        v.i1 = i1; v.a1 = a1; v.i2 = i2; v.a2 = a2;
        v.ev1 = ev1; v.ev2 = ev2; v.efull = efull; v.eempty = eempty;
        v.ei1 = ei1; v.ea1 = ea1; v.ei2 = ei2; v.ea2 = ea2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0; write_en1 = 1'b0; write_en2 = 1'b0;
        read_en1 = 1'b0; read_en2 = 1'b0;
        write_inst1 = '0; write_inst2 = '0; write_addr1 = '0; write_addr2 = '0;
    endtask

    task automatic drive(input logic fl, w1, w2, r1, r2,
                         input logic [31:0] i1, a1, i2, a2);
        @(negedge clk);
        flush = fl; write_en1 = w1; write_en2 = w2; read_en1 = r1; read_en2 = r2;
        write_inst1 = i1; write_addr1 = a1; write_inst2 = i2; write_addr2 = a2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic chk_head(input string nm, input logic v1, input logic [31:0] i1, a1,
                            input logic v2, input logic [31:0] i2, a2);
        chk({nm, ".valid1"}, 32'(read_valid1), 32'(v1));
        chk({nm, ".inst1"}, read_inst1, i1);
        chk({nm, ".addr1"}, read_addr1, a1);
        chk({nm, ".valid2"}, 32'(read_valid2), 32'(v2));
        chk({nm, ".inst2"}, read_inst2, i2);
        chk({nm, ".addr2"}, read_addr2, a2);
    endtask

    function automatic logic [31:0] fi(input int k); return 32'hF000_0000 + 32'(k); endfunction
    function automatic logic [31:0] fa(input int k); return 32'h8000_0000 + 32'(4 * k); endfunction
    function automatic logic [31:0] si(input int k); return 32'h5000_0000 + 32'(k); endfunction
    function automatic logic [31:0] sa(input int k); return 32'h0040_0000 + 32'(4 * k); endfunction

    initial begin
        vec_t v;
        rst = 1'b0;
        idle();
        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.full", 32'(full), 32'd0);
        chk_head("rst", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        //           fl w1 w2 r1 r2  inst1         addr1         inst2         addr2          ev1 ev2 full empty  exp inst1/addr1/inst2/addr2
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h24020001, 32'hBFC00000, 32'h24030002, 32'hBFC00004, 1, 1, 0, 0, 32'h24020001, 32'hBFC00000, 32'h24030002, 32'hBFC00004));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0,                          1, 0, 0, 0, 32'h24030002, 32'hBFC00004, 32'h0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0,                          0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0,                          0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h44444444, 32'h0000100C,            0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h11111111, 32'h00001000, 32'h22222222, 32'h00001004, 1, 1, 0, 0, 32'h11111111, 32'h00001000, 32'h22222222, 32'h00001004));
        vecs.push_back(mk(0, 1, 1, 1, 1, 32'h33333333, 32'h00001008, 32'h44444444, 32'h0000100C, 1, 1, 0, 0, 32'h33333333, 32'h00001008, 32'h44444444, 32'h0000100C));
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h55555555, 32'h00001010, 32'h66666666, 32'h00001014, 1, 1, 0, 0, 32'h44444444, 32'h0000100C, 32'h55555555, 32'h00001010));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0,                          1, 1, 0, 0, 32'h44444444, 32'h0000100C, 32'h55555555, 32'h00001010));
        vecs.push_back(mk(1, 1, 1, 1, 0, 32'h77777777, 32'h00002000, 32'h88888888, 32'h00002004, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.fl, v.w1, v.w2, v.r1, v.r2, v.i1, v.a1, v.i2, v.a2);
            step();
            chk_head($sformatf("vec%0d", i), v.ev1, v.ei1, v.ea1, v.ev2, v.ei2, v.ea2);
            chk($sformatf("vec%0d.full", i), 32'(full), 32'(v.efull));
            chk($sformatf("vec%0d.empty", i), 32'(empty), 32'(v.eempty));
        end

        // Fill to 16 with pair pushes; full rises once count reaches 15
        for (int p = 0; p < 8; p++) begin
            drive(0, 1, 1, 0, 0, fi(2 * p), fa(2 * p), fi(2 * p + 1), fa(2 * p + 1));
            step();
            chk($sformatf("fill%0d.full", p), 32'(full), (2 * p + 2 >= 15) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d.head", p), read_inst1, fi(0));
        end
        drive(0, 1, 1, 0, 0, 32'hDEAD0000, 32'h0, 32'hDEAD0001, 32'h4);
        step();
        chk("full16.full", 32'(full), 32'd1);
        drive(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
        chk("full15.full", 32'(full), 32'd1);
        chk_head("full15", 1'b1, fi(1), fa(1), 1'b1, fi(2), fa(2));
        // Tail now points at a free slot directly behind a live one: a dropped push must not land
        drive(0, 1, 1, 0, 0, 32'hDEAD0002, 32'h8, 32'hDEAD0003, 32'hC);
        step();
        for (int k = 1; k <= 15; k++) begin
            chk($sformatf("drain%0d.inst1", k), read_inst1, fi(k));
            chk($sformatf("drain%0d.valid2", k), 32'(read_valid2), (k < 15) ? 32'd1 : 32'd0);
            if (k < 15) chk($sformatf("drain%0d.inst2", k), read_inst2, fi(k + 1));
            drive(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
            step();
            if (k == 1) chk("drain.full_low", 32'(full), 32'd0);
        end
        chk("drain.empty", 32'(empty), 32'd1);
        chk("drain.valid1", 32'(read_valid1), 32'd0);

        // Streaming: push 2 + pop 2 for 20 cycles, steady at count 2 across several wraps
        drive(0, 1, 1, 0, 0, si(0), sa(0), si(1), sa(1));
        step();
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 1, 1, 1, si(2 * k + 2), sa(2 * k + 2), si(2 * k + 3), sa(2 * k + 3));
            step();
            chk_head($sformatf("stream%0d", k), 1'b1, si(2 * k + 2), sa(2 * k + 2),
                     1'b1, si(2 * k + 3), sa(2 * k + 3));
            chk($sformatf("stream%0d.empty", k), 32'(empty), 32'd0);
        end
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();

        // Flush at count 6 together with a push
        for (int p = 0; p < 3; p++) begin
            drive(0, 1, 1, 0, 0, fi(40 + 2 * p), fa(40 + 2 * p), fi(41 + 2 * p), fa(41 + 2 * p));
            step();
        end
        chk("pre_flush.empty", 32'(empty), 32'd0);
        drive(1, 1, 1, 1, 0, 32'hBAD00000, 32'h0, 32'hBAD00001, 32'h4);
        step();
        chk("flush.empty", 32'(empty), 32'd1);
        chk_head("flush", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        drive(0, 1, 1, 0, 0, 32'hCAFE0000, 32'h00003000, 32'hCAFE0001, 32'h00003004);
        step();
        chk_head("post_flush", 1'b1, 32'hCAFE0000, 32'h00003000, 1'b1, 32'hCAFE0001, 32'h00003004);

        // Reset wins over flush and a same-cycle push
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b1; write_en1 = 1'b1; write_en2 = 1'b1;
        write_inst1 = 32'hABCD0000; write_inst2 = 32'hABCD0001;
        step();
        rst = 1'b1;
        chk("rst_mid.empty", 32'(empty), 32'd1);
        chk("rst_mid.valid1", 32'(read_valid1), 32'd0);

`ifdef INST_FIFO_BYPASS_EN
        // Empty FIFO, push pair with read_en1 only: inst1 visible and consumed the same cycle
        drive(0, 1, 1, 1, 0, 32'h12340000, 32'h00005000, 32'h12340001, 32'h00005004);
        #1;
        chk_head("bypass.same", 1'b1, 32'h12340000, 32'h00005000, 1'b1, 32'h12340001, 32'h00005004);
        step();
        chk_head("bypass.next", 1'b1, 32'h12340001, 32'h00005004, 1'b0, 32'h0, 32'h0);
        chk("bypass.empty", 32'(empty), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
